// File: rtl/sha256.sv
// sha256 -- iterative SHA-256 compression core, one round per clock.
// Free-runs LOAD -> ROUND x64 -> DONE; chaining state is carried across the
// blocks of a message, whose length (1 or 2 blocks) is taken from blk_type
// when the first block of the message is loaded.
module sha256 (
    input  logic         CLK,
    input  logic         nreset,     // asynchronous, active-high
    input  logic [511:0] msg,
    input  logic [1:0]   blk_type,
    output logic [255:0] hash,
    output logic         blk_done
);

    typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DONE} state_t;

    // IV packed so that IV[0] = H0
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t            r_state;
    logic [5:0]        r_rnd;
    logic              r_blk;      // index of the current block within its message
    logic [1:0]        r_len;      // blk_type latched at the first block
    logic [15:0][31:0] r_w;        // schedule window, r_w[0] = W_t
    logic [7:0][31:0]  r_wk;       // working regs a..h, r_wk[0] = a
    logic [7:0][31:0]  r_cv;       // chaining value, r_cv[0] = H0

    logic [31:0]       w_s0, w_s1, w_wnew;
    logic [31:0]       w_bs0, w_bs1, w_ch, w_maj, w_t1, w_t2;
    logic [7:0][31:0]  w_wk_next, w_cv_next, w_base;
    logic [255:0]      w_hash_next;
    logic              w_last;

    // round datapath, schedule extension and chaining update
    always_comb begin
        w_s0   = rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3);
        w_s1   = rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10);
        w_wnew = w_s1 + r_w[9] + w_s0 + r_w[0];

        w_bs1 = rotr(r_wk[4], 6) ^ rotr(r_wk[4], 11) ^ rotr(r_wk[4], 25);
        w_ch  = (r_wk[4] & r_wk[5]) ^ (~r_wk[4] & r_wk[6]);
        w_t1  = r_wk[7] + w_bs1 + w_ch + K[r_rnd] + r_w[0];
        w_bs0 = rotr(r_wk[0], 2) ^ rotr(r_wk[0], 13) ^ rotr(r_wk[0], 22);
        w_maj = (r_wk[0] & r_wk[1]) ^ (r_wk[0] & r_wk[2]) ^ (r_wk[1] & r_wk[2]);
        w_t2  = w_bs0 + w_maj;

        w_wk_next    = r_wk;
        w_wk_next[0] = w_t1 + w_t2;
        w_wk_next[1] = r_wk[0];
        w_wk_next[2] = r_wk[1];
        w_wk_next[3] = r_wk[2];
        w_wk_next[4] = r_wk[3] + w_t1;
        w_wk_next[5] = r_wk[4];
        w_wk_next[6] = r_wk[5];
        w_wk_next[7] = r_wk[6];

        w_cv_next = r_cv;
        for (int i = 0; i < 8; i++)
            w_cv_next[i] = r_cv[i] + w_wk_next[i];

        w_hash_next = {w_cv_next[0], w_cv_next[1], w_cv_next[2], w_cv_next[3],
                       w_cv_next[4], w_cv_next[5], w_cv_next[6], w_cv_next[7]};

        // a new message always starts from IV, later blocks from the carried value
        w_base = r_blk ? r_cv : IV;
        // 2-block message types are 1 and 2; HASH and reserved are 1 block
        w_last = (r_len == 2'd1 || r_len == 2'd2) ? r_blk : 1'b1;
    end

    // sequencer, schedule window, working/chaining regs and registered outputs
    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) begin
            r_state  <= S_LOAD;
            r_rnd    <= '0;
            r_blk    <= 1'b0;
            r_len    <= '0;
            r_w      <= '0;
            r_wk     <= '0;
            r_cv     <= IV;
            hash     <= '0;
            blk_done <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < 16; i++)
                        r_w[i] <= msg[511 - 32*i -: 32];
                    if (!r_blk) begin
                        r_len <= blk_type;
                        r_cv  <= IV;
                    end
                    r_wk     <= w_base;
                    r_rnd    <= '0;
                    blk_done <= 1'b0;
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_w   <= {w_wnew, r_w[15:1]};
                    r_wk  <= w_wk_next;
                    r_rnd <= r_rnd + 6'd1;
                    if (r_rnd == 6'd63) begin
                        r_cv     <= w_cv_next;
                        hash     <= w_hash_next;
                        blk_done <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    blk_done <= 1'b0;
                    r_blk    <= w_last ? 1'b0 : 1'b1;
                    r_state  <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256.sv
// tb_sha256 -- directed and random blocks against a FIPS-style SHA-256 model.
module tb_sha256;

    logic         CLK = 1'b0;
    logic         nreset;
    logic [511:0] msg;
    logic [1:0]   blk_type;
    logic [255:0] hash;
    logic         blk_done;

    int vectors = 0;
    int miscompares = 0;

    sha256 dut (
        .CLK      (CLK),
        .nreset   (nreset),
        .msg      (msg),
        .blk_type (blk_type),
        .hash     (hash),
        .blk_done (blk_done)
    );

    always #5 CLK = ~CLK;

    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // textbook compression: full 64-word schedule, then 64 rounds
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            v[i]  = hv[i];
        end
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    // message-level model state
    logic [255:0] m_chain;
    int           m_cnt  = 0;
    int           m_nblk = 1;

    task automatic check256(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // counts rising edges until blk_done is seen (sampled 1 unit after the edge)
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!blk_done && n < 200);
        check_int("done_seen", int'(blk_done), 1);
    endtask

    // Present one block, advance the model, check gap, digest and pulse width.
    // Called either before reset release or one edge after the previous pulse;
    // both leave 65 edges to the next pulse (66-cycle pulse spacing).
    task automatic run_block(input logic [511:0] b, input logic [1:0] t, input string tag);
        int n;
        msg = b;
        blk_type = t;
        if (m_cnt == 0) begin
            m_chain = IV256;
            m_nblk  = (t == 2'd1 || t == 2'd2) ? 2 : 1;
        end
        m_chain = ref_compress(m_chain, b);
        m_cnt++;
        if (m_cnt == m_nblk) m_cnt = 0;
        wait_done(n);
        check_int({tag, "_gap"}, n, 65);
        check256(tag, hash, m_chain);
        @(posedge CLK); #1;
        check_int({tag, "_pulse"}, int'(blk_done), 0);
    endtask

    logic [511:0] blk_abc, blk_empty, blk_m1, blk_m2, rb;
    logic [1:0]   rt;
    int           n;

    initial begin
        blk_abc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
        blk_empty = {32'h80000000, {15{32'h0}}};
        blk_m1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_m2    = {{15{32'h0}}, 32'h000001c0};

        // reset state
        nreset   = 1'b1;
        msg      = blk_abc;
        blk_type = 2'd0;
        repeat (3) @(posedge CLK);
        #1;
        check256("rst_hash", hash, '0);
        check_int("rst_done", int'(blk_done), 0);

        // first pulse 65 edges after release, "abc"
        @(negedge CLK);
        nreset = 1'b0;
        run_block(blk_abc, 2'd0, "abc");
        check256("abc_digest", hash, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        run_block(blk_empty, 2'd0, "empty");
        check256("empty_digest", hash, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        // two-block Merkle leaf; blk_type on block 2 must be ignored
        run_block(blk_m1, 2'd1, "merkle_b1");
        run_block(blk_m2, 2'd0, "merkle_b2");
        check256("merkle_digest", hash, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        // next message restarts from IV
        run_block(blk_abc, 2'd3, "abc_again");
        check256("abc_again_digest", hash, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // random messages of random type, random blk_type on later blocks
        for (int m = 0; m < 6; m++) begin
            rt = 2'($urandom_range(0, 3));
            for (int b = 0; b < ((rt == 2'd1 || rt == 2'd2) ? 2 : 1); b++) begin
                for (int k = 0; k < 16; k++) rb[511 - 32*k -: 32] = $urandom;
                run_block(rb, (b == 0) ? rt : 2'($urandom_range(0, 3)), "rand");
            end
        end

        // reset around round 30 aborts the block; it is recomputed from IV
        msg      = blk_abc;
        blk_type = 2'd0;
        repeat (31) @(posedge CLK);
        @(negedge CLK);
        nreset = 1'b1;
        #1;
        check256("midrst_hash", hash, '0);
        check_int("midrst_done", int'(blk_done), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nreset = 1'b0;
        m_cnt = 0;
        wait_done(n);
        check_int("midrst_gap", n, 65);
        check256("midrst_digest", hash, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256.md
Name: sha256

Overview:
- Iterative SHA-256 compression core that hashes a message presented as a sequence of pre-padded 512-bit blocks.
- One round per clock; the chaining state is carried between the blocks of a message.
- The number of blocks per message comes from blk_type: single-block hash, 2-block Merkle leaf, or 2-block 80-byte block header.
- Used by the mining datapath for double-hash, Merkle-node and header hashing.

Parameters:
- none (SHA-256 constants K[0..63] and IV H0..H7 are fixed per FIPS 180-4)

Ports:
- CLK  in  1  rising-edge clock.
- nreset  in  1  reset; asynchronous, active-high (1 = reset), despite the name.
- msg  in  512  current padded block; msg[511:480] = W0 … msg[31:0] = W15, big-endian words.
- blk_type  in  2  0 = HASH (1 block), 1 = MERKLE_LEAF (2 blocks), 2 = HEADER (2 blocks), 3 = reserved (treated as HASH).
- hash  out  256  chaining value H0..H7 concatenated, H0 in [255:224].
- blk_done  out  1  one-cycle pulse when a block's compression completes and hash is updated.

Behaviour:
- No start handshake. The core free-runs: LOAD → ROUND ×64 → DONE → LOAD …, one block per 66 cycles.
- Reset (nreset=1, async):
  - state = LOAD, blk_done = 0, hash = 0.
  - Block counter = 0, chaining regs = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Reset mid-block aborts the block with no output.
- LOAD (1 cycle), at its closing edge:
  - Capture msg into the 16-word schedule window.
  - If block counter = 0: capture blk_type into the message-length register and load chaining regs with IV.
  - Working regs a..h = chaining regs.
  - blk_type is ignored on later blocks of the same message.
- ROUND (64 cycles, t = 0..63):
  - W_t = window word 0.
  - Window shifts left, appending σ1(W14)+W9+σ0(W1)+W0 (mod 2^32).
  - T1 = h+Σ1(e)+Ch(e,f,g)+K_t+W_t; T2 = Σ0(a)+Maj(a,b,c).
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions mod 2^32.
- At the closing edge of round 63:
  - Chaining H_i += working reg (mod 2^32).
  - hash ← updated chaining value.
  - State → DONE.
- DONE (1 cycle):
  - blk_done = 1, asserted for exactly one cycle.
  - Block counter increments; it clears to 0 if this was the last block (1 block for HASH/reserved, 2 otherwise).
  - Then → LOAD.
- msg sampling timing: msg must be stable at the closing edge of LOAD, which is the second rising edge after blk_done rises. Changing msg on the edge where blk_done rises is therefore safe.
- hash:
  - Holds its value between updates.
  - After a non-final block it shows the intermediate chaining value; after the final block it is the message digest.
  - The next message starts from IV automatically.
- Padding and length fields are the producer's responsibility; the core never pads.
- Timing:
  - blk_done first rises 65 cycles after reset release; LOAD occupies the first cycle.
  - Subsequent blk_done pulses are exactly 66 cycles apart.

Test Plan:
- HASH, "abc" block (61626380, zeros, length 0x18) → hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad at the first blk_done.
- HASH, empty message (80000000…, length 0) → hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- MERKLE_LEAF, two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: block 1 = 448-bit message + 0x80 + zeros; block 2 = zeros + length 0x1c0; msg swapped on the blk_done edge.
  - Required: second blk_done → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Back-to-back: after the 2-block message, a HASH "abc" block → ba7816bf…15ad, proving IV reload and counter wrap.
- Timing: count cycles → blk_done high exactly 1 cycle; pulses 66 cycles apart; first pulse 65 cycles after reset release.
- Reset at round ~30: assert nreset → hash = 0 and blk_done = 0 immediately. Release → same block recomputed from IV, correct digest 65 cycles later.
